stack_unit: RTL

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//
// Purpose:
//   Register-based LIFO return-address stack. Slot i sits at data-memory
//   address BASE_ADDR+i; sp is the next free address (BASE_ADDR + count).
//   A pop returns the top entry on pop_data with a one-cycle pop_valid pulse.
//   A simultaneous push and pop on a non-empty stack replaces the top entry.
//
// Parameters:
//   WIDTH      data word width
//   DEPTH      number of stack entries (>= 2)
//   BASE_ADDR  data-memory address of slot 0
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   push / pop     requests sampled on the rising edge
//   push_data      word to push (return address on CALL)
//   err_clear      clears the sticky error flags
//   pop_data       registered popped word
//   pop_valid      one-cycle pulse qualifying pop_data
//   top_data       combinational top entry, 0 when empty
//   sp             BASE_ADDR + count (next free address)
//   full / empty   count == DEPTH / count == 0
//   overflow_err   sticky push-while-full
//   underflow_err  sticky pop-while-empty
//
// Configuration:
//   STACK_UNIT_ERROR_FLAGS_EN  when defined, builds the sticky error flags and
//                              err_clear handling; otherwise both flags are 0.
// -----------------------------------------------------------------------------
module stack_unit #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int BASE_ADDR = 224
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             err_clear,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top_data,
    output logic [31:0]      sp,
    output logic             full,
    output logic             empty,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_pop_data;
    logic             r_pop_valid;

    logic             w_full;
    logic             w_empty;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_free_idx;
    logic [AW-1:0]    w_wr_idx;
    logic             w_pop_ok;
    logic             w_wr_en;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    // Top index is meaningless while empty; every consumer is gated by w_empty.
    assign w_top_idx  = AW'(r_count - CW'(1));
    assign w_free_idx = AW'(r_count);

    assign w_pop_ok   = pop & ~w_empty;
    // A push lands whenever it is paired with a pop (replace top, or fill the
    // empty slot 0) or when there is room.
    assign w_wr_en    = push & (pop | ~w_full);
    assign w_wr_idx   = w_pop_ok ? w_top_idx : w_free_idx;

    assign w_ovf_set  = push & ~pop & w_full;
    assign w_unf_set  = pop & w_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (push && !pop && !w_full) begin
            w_count_nxt = r_count + CW'(1);
        end else if (pop && !push && !w_empty) begin
            w_count_nxt = r_count - CW'(1);
        end else if (push && pop && w_empty) begin
            // Pop rejected, push accepted into slot 0.
            w_count_nxt = CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_pop_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_pop_data <= r_mem[w_top_idx];
            end
        end
    end

    // Storage has no reset. A write landing while reset is held only touches
    // a slot above count (count is 0), so it is never observable.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

`ifdef STACK_UNIT_ERROR_FLAGS_EN
    logic r_ovf;
    logic r_unf;

    // A new error in the same cycle as err_clear wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (err_clear) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (err_clear) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;
`else
    logic w_unused_err;
    assign w_unused_err  = err_clear | w_ovf_set | w_unf_set;
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;
    assign top_data  = w_empty ? '0 : r_mem[w_top_idx];
    assign sp        = 32'(BASE_ADDR) + 32'(r_count);
    assign full      = w_full;
    assign empty     = w_empty;

endmodule
